// File: rtl/key_debounce_if.sv
// Key debouncer port bundle: raw push-button levels in, debounced level and
// press/release pulses out. master = key source/observer, slave = debouncer.
interface key_debounce_if;
  logic       KEY0;
  logic       KEY1;
  logic       KEY2;
  logic [2:0] key_state;
  logic [2:0] key_press;
  logic [2:0] key_release;

  modport master (
    output KEY0, KEY1, KEY2,
    input  key_state, key_press, key_release
  );

  modport slave (
    input  KEY0, KEY1, KEY2,
    output key_state, key_press, key_release
  );
endinterface

// File: rtl/key_debounce.sv
// Three-key debouncer with per-key STABLE/CHANGING FSM, registered press and
// release pulses. Optional auto-repeat of key_press is enabled by the macro
// KEY_REPEAT_EN; without it the REPEAT_* parameters have no effect.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input logic           clk,
  input logic           rst,
  key_debounce_if.slave keys
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] DebMax = CntW'(DEBOUNCE_CYCLES);
  localparam logic [2:0] Released = {3{KEY_ACTIVE_LOW}};

  typedef enum logic {StStable, StChanging} deb_state_e;

  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] pressed;
  logic [2:0] state_q, press_q, release_q;
  logic [2:0] flip;
  logic [2:0] rep_fire;

  assign raw     = {keys.KEY2, keys.KEY1, keys.KEY0};
  assign pressed = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Two-flop synchronizer, reset to the released level so no edge appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= Released;
      sync2_q <= Released;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar n = 0; n < 3; n++) begin : g_key
    deb_state_e      st_q, st_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            flip_n;

    // Debounce FSM next state: count consecutive mismatches, flip at DebMax.
    always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      flip_n = 1'b0;
      unique case (st_q)
        StStable: begin
          if (pressed[n] != state_q[n]) begin
            st_d  = StChanging;
            cnt_d = CntW'(1);
          end
        end
        StChanging: begin
          if (pressed[n] == state_q[n]) begin
            st_d  = StStable;
            cnt_d = '0;
          end else if (cnt_q == DebMax) begin
            flip_n = 1'b1;
            st_d   = StStable;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          st_d  = StStable;
          cnt_d = '0;
        end
      endcase
    end

    // Debounce FSM state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q  <= StStable;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign flip[n] = flip_n;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                   : REPEAT_PERIOD;
    localparam int unsigned RepW = $clog2(RepMax) + 1;
    localparam logic [RepW-1:0] RepDelay  = RepW'(REPEAT_DELAY);
    localparam logic [RepW-1:0] RepPeriod = RepW'(REPEAT_PERIOD);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep_phase_q, rep_phase_d;
    logic            rep_fire_n;

    // Repeat timer: restart on accepted press, clear while released or releasing.
    always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      rep_fire_n  = 1'b0;
      if (flip_n && !state_q[n]) begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
      end else if (!state_q[n] || flip_n) begin
        rep_cnt_d   = '0;
        rep_phase_d = 1'b0;
      end else if ((rep_cnt_q + RepW'(1)) == (rep_phase_q ? RepPeriod : RepDelay)) begin
        rep_fire_n  = 1'b1;
        rep_cnt_d   = '0;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RepW'(1);
      end
    end

    // Repeat timer registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b0;
      end else begin
        rep_cnt_q   <= rep_cnt_d;
        rep_phase_q <= rep_phase_d;
      end
    end

    assign rep_fire[n] = rep_fire_n;
`else
    assign rep_fire[n] = 1'b0;
`endif
  end

`ifndef KEY_REPEAT_EN
  // Repeat parameters are deliberately inert in this build.
  if (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_repeat_params_inert
  end
`endif

  // Registered outputs: level, press (accept or repeat) and release pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      state_q   <= state_q ^ flip;
      press_q   <= (flip & ~state_q) | rep_fire;
      release_q <= flip & state_q;
    end
  end

  assign keys.key_state   = state_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, active-low keys,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Repeat expectations follow KEY_REPEAT_EN.
module tb_key_debounce;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  key_debounce_if kif();

  key_debounce #(
    .DEBOUNCE_CYCLES (4),
    .KEY_ACTIVE_LOW  (1'b1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .keys (kif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [8:0] got;
    kif.KEY0 = 1'b1;
    kif.KEY1 = 1'b1;
    kif.KEY2 = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      checks++;
      if (got !== 9'b0) begin
        failures++;
        $display("FAIL reset_during cycle %0d: got %b expected %b", i, got, 9'b0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      checks++;
      if (got !== 9'b0) begin
        failures++;
        $display("FAIL reset_after cycle %0d: got %b expected %b", i, got, 9'b0);
      end
    end
  endtask

  task automatic test_press_release();
    logic [8:0] got, exp;
    @(negedge clk);
    kif.KEY1 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(i >= 7) ? 3'b010 : 3'b000, (i == 7) ? 3'b010 : 3'b000, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL key1_press cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    @(negedge clk);
    kif.KEY1 = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(j < 7) ? 3'b010 : 3'b000, 3'b000, (j == 7) ? 3'b010 : 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL key1_release cycle %0d: got %b expected %b", j, got, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [8:0] got, exp;
    @(negedge clk);
    kif.KEY0 = 1'b0;
    idle(3);
    @(negedge clk);
    kif.KEY0 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      checks++;
      if (got !== 9'b0) begin
        failures++;
        $display("FAIL key0_glitch cycle %0d: got %b expected %b", i, got, 9'b0);
      end
    end
    @(negedge clk);
    kif.KEY0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(i >= 7) ? 3'b001 : 3'b000, (i == 7) ? 3'b001 : 3'b000, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL key0_stable_press cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    @(negedge clk);
    kif.KEY0 = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(j < 7) ? 3'b001 : 3'b000, 3'b000, (j == 7) ? 3'b001 : 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL key0_release cycle %0d: got %b expected %b", j, got, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] got, exp;
    @(negedge clk);
    kif.KEY0 = 1'b0;
    kif.KEY2 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(i >= 7) ? 3'b101 : 3'b000, (i == 7) ? 3'b101 : 3'b000, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL dual_press cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    @(negedge clk);
    kif.KEY0 = 1'b1;
    kif.KEY2 = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(j < 7) ? 3'b101 : 3'b000, 3'b000, (j == 7) ? 3'b101 : 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL dual_release cycle %0d: got %b expected %b", j, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [8:0] got, exp;
    @(negedge clk);
    kif.KEY2 = 1'b0;
    idle(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      got = {kif.key_state, kif.key_press, kif.key_release};
      checks++;
      if (got !== 9'b0) begin
        failures++;
        $display("FAIL rst_mid_debounce cycle %0d: got %b expected %b", i, got, 9'b0);
      end
      tick();
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(i >= 7) ? 3'b100 : 3'b000, (i == 7) ? 3'b100 : 3'b000, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL key2_held_after_rst cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    @(negedge clk);
    kif.KEY2 = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(j < 7) ? 3'b100 : 3'b000, 3'b000, (j == 7) ? 3'b100 : 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL key2_release cycle %0d: got %b expected %b", j, got, exp);
      end
    end
  endtask

  task automatic test_repeat();
    logic [8:0] got, exp;
    logic       rep;
    @(negedge clk);
    kif.KEY1 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(i == 7) ? 3'b010 : 3'b000, (i == 7) ? 3'b010 : 3'b000, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL repeat_accept cycle %0d: got %b expected %b", i, got, exp);
      end
    end
    // k counts clocks after the accepted press.
    for (int k = 1; k <= 30; k++) begin
      tick();
`ifdef KEY_REPEAT_EN
      rep = (k >= 10) && (((k - 10) % 3) == 0);
`else
      rep = 1'b0;
`endif
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {3'b010, rep ? 3'b010 : 3'b000, 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL repeat_hold +%0d: got %b expected %b", k, got, exp);
      end
    end
    // Release accepted at +37, where a repeat would also fall: it must be dropped.
    @(negedge clk);
    kif.KEY1 = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
`ifdef KEY_REPEAT_EN
      rep = (j < 7) && ((((30 + j) - 10) % 3) == 0);
`else
      rep = 1'b0;
`endif
      got = {kif.key_state, kif.key_press, kif.key_release};
      exp = {(j < 7) ? 3'b010 : 3'b000, rep ? 3'b010 : 3'b000,
             (j == 7) ? 3'b010 : 3'b000};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL repeat_release +%0d: got %b expected %b", 30 + j, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    idle(3);
    test_press_release();
    idle(3);
    test_glitch();
    idle(3);
    test_simultaneous();
    idle(3);
    test_reset_mid_debounce();
    idle(3);
    test_repeat();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
